// File: rtl/arbiter_rr_n_pkg.sv
// rtl/arbiter_rr_n_pkg.sv - shared types, constants and helpers for the N-requester arbiter
package tiny_axi_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int ARB_MODE_RR    = 0;
    localparam int ARB_MODE_FIXED = 1;

    // Owner index width; a single requester bit still needs one index bit
    function automatic int arb_idxw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arbiter_rr_n_if.sv
// rtl/arbiter_rr_n_if.sv - request/grant bundle between requesters and the arbiter
interface arbiter_rr_n_if
    import tiny_axi_arb_pkg::*;
#(
    parameter int NREQ = 4
);
    localparam int IDXW = arb_idxw(NREQ);

    logic [NREQ-1:0] req;
    logic            finish;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] sel;
    logic [IDXW-1:0] owner;
    logic            busy;
    logic            timeout;

    modport master (
        output req, finish,
        input  gnt, sel, owner, busy, timeout
    );

    modport slave (
        input  req, finish,
        output gnt, sel, owner, busy, timeout
    );
endinterface

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - rotating priority encoder: first set request at or after start
module arb_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] start,
    output logic            found,
    output logic [IDXW-1:0] idx
);
    logic [IDXW-1:0] cand;

    // Walk NREQ candidates from start, wrapping by compare since NREQ may not be a power of two
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = start;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
            cand = (cand == IDXW'(NREQ - 1)) ? '0 : cand + IDXW'(1);
        end
    end
endmodule

// File: rtl/arbiter_rr_n.sv
// rtl/arbiter_rr_n.sv - N-requester tenure arbiter, round-robin or fixed priority, optional timeout
module arbiter_rr_n
    import tiny_axi_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MODE    = ARB_MODE_RR,
    parameter int TIMEOUT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    arbiter_rr_n_if.slave bus
);
    localparam int IDXW = arb_idxw(NREQ);
    localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t      state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] owner_q;
    logic [NREQ-1:0] sel_q;
    logic [NREQ-1:0] gnt_q;

    logic [IDXW-1:0] owner_nxt;
    logic [IDXW-1:0] start;
    logic            found;
    logic [IDXW-1:0] win;
    logic            to_hit;
    logic            release_now;
    logic            grant_now;

    // Slot after the current owner, so a releasing owner is searched last
    assign owner_nxt = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + IDXW'(1);

    assign release_now = (state == ARB_BUSY) && (bus.finish || to_hit);
    assign grant_now   = found && ((state == ARB_IDLE) || release_now);

    // Fixed priority always searches from 0; round-robin from ptr, or owner+1 on release
    assign start = (MODE == ARB_MODE_FIXED) ? '0 :
                   (release_now ? owner_nxt : ptr);

    arb_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req   (bus.req),
        .start (start),
        .found (found),
        .idx   (win)
    );

    // Tenure counter: gnt cycle counts as 1; finish takes precedence over a timeout
    generate
        if (TIMEOUT > 0) begin : g_tmo
            logic [CW-1:0] cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (grant_now) begin
                    cnt <= CW'(1);
                end else if (release_now) begin
                    cnt <= '0;
                end else if (state == ARB_BUSY && cnt != CW'(TIMEOUT)) begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign to_hit = (state == ARB_BUSY) && !bus.finish && (cnt == CW'(TIMEOUT));
        end else begin : g_no_tmo
            assign to_hit = 1'b0;
        end
    endgenerate

    // Tenure FSM: registers owner, select and the one-cycle grant pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            ptr     <= '0;
            owner_q <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
        end else begin
            gnt_q <= '0;
            case (state)
                ARB_IDLE: begin
                    if (found) begin
                        state   <= ARB_BUSY;
                        owner_q <= win;
                        sel_q   <= NREQ'(1) << win;
                        gnt_q   <= NREQ'(1) << win;
                    end
                end
                ARB_BUSY: begin
                    if (release_now) begin
                        ptr <= owner_nxt;
                        if (found) begin
                            owner_q <= win;
                            sel_q   <= NREQ'(1) << win;
                            gnt_q   <= NREQ'(1) << win;
                        end else begin
                            state   <= ARB_IDLE;
                            owner_q <= '0;
                            sel_q   <= '0;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.owner   = owner_q;
    assign bus.busy    = (state == ARB_BUSY);
    assign bus.timeout = to_hit;
endmodule
